// File: rtl/caesar_decrypt.sv
// Shift-cipher decrypt: byte/key FIFO followed by a key-normalise stage and a rotate stage.
// Optional CAESAR_DEC_CNT_EN adds char_cnt, a saturating count of bytes delivered on dout.
module caesar_decrypt #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [4:0]   shift,
    input  logic [1:0]   direction,
    output logic [N-1:0] dout,
    output logic         v,
    input  logic         dout_ready
`ifdef CAESAR_DEC_CNT_EN
    ,
    output logic [15:0]  char_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = N + 7;

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [CW-1:0]  r_cnt;

    logic           r_s0_vld;
    logic [N-1:0]   r_s0_byte;
    logic [4:0]     r_s0_shift;
    logic [1:0]     r_s0_dir;

    logic           r_s1_vld;
    logic [N-1:0]   r_s1_byte;
    logic [4:0]     r_s1_k;
    logic [1:0]     r_s1_dir;

    logic [N-1:0]   r_dout;
    logic           r_v;

    logic           w_adv_out, w_adv_s1, w_adv_s0;
    logic           w_wr, w_rd, w_full;
    logic [CW-1:0]  w_occ;
    logic [4:0]     w_k;
    logic           w_is_up, w_is_lo;
    logic [N-1:0]   w_base;
    logic [5:0]     w_off, w_sum, w_rot;
    logic [N-1:0]   w_plain;

    // The read register counts toward FIFO occupancy, so DEPTH bytes buffer ahead of stage 1.
    assign w_occ     = r_cnt + CW'(r_s0_vld);
    assign w_full    = (w_occ >= CW'(DEPTH));
    assign din_ready = rst && en && !w_full;

    assign w_adv_out = !r_v || dout_ready;
    assign w_adv_s1  = !r_s1_vld || w_adv_out;
    assign w_adv_s0  = !r_s0_vld || w_adv_s1;
    assign w_wr      = din_valid && din_ready;
    assign w_rd      = (r_cnt != '0) && w_adv_s0;

    assign dout = r_dout;
    assign v    = r_v;

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr] <= {din, shift, direction};
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + AW'(1);
            if (w_rd) r_rptr <= r_rptr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign w_k = (r_s0_shift >= 5'd26) ? r_s0_shift - 5'd26 : r_s0_shift;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_s0_vld   <= 1'b0;
            r_s0_byte  <= '0;
            r_s0_shift <= '0;
            r_s0_dir   <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_byte  <= '0;
            r_s1_k     <= '0;
            r_s1_dir   <= '0;
            r_dout     <= '0;
            r_v        <= 1'b0;
        end else begin
            if (w_adv_s0) begin
                r_s0_vld <= w_rd;
                if (w_rd) {r_s0_byte, r_s0_shift, r_s0_dir} <= r_mem[r_rptr];
            end
            if (w_adv_s1) begin
                r_s1_vld <= r_s0_vld;
                if (r_s0_vld) begin
                    r_s1_byte <= r_s0_byte;
                    r_s1_k    <= w_k;
                    r_s1_dir  <= r_s0_dir;
                end
            end
            if (w_adv_out) begin
                r_v <= r_s1_vld;
                if (r_s1_vld) r_dout <= w_plain;
            end
        end
    end

    // Rotation works on the low 6 bits: both case ranges map to offsets 0..25 there.
    always_comb begin
        w_is_up = (r_s1_byte >= 8'h41) && (r_s1_byte <= 8'h5A);
        w_is_lo = (r_s1_byte >= 8'h61) && (r_s1_byte <= 8'h7A);
        w_base  = w_is_up ? 8'h41 : 8'h61;
        w_off   = r_s1_byte[5:0] - w_base[5:0];
        if (r_s1_dir[1]) w_sum = w_off + {1'b0, r_s1_k};
        else             w_sum = w_off + 6'd26 - {1'b0, r_s1_k};
        w_rot   = (w_sum >= 6'd26) ? w_sum - 6'd26 : w_sum;
        w_plain = r_s1_byte;
        if ((w_is_up || w_is_lo) && !r_s1_dir[0]) w_plain = w_base + {2'b00, w_rot};
    end

`ifdef CAESAR_DEC_CNT_EN
    logic [15:0] r_char_cnt;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst)                                       r_char_cnt <= '0;
        else if (r_v && dout_ready && r_char_cnt != 16'hFFFF) r_char_cnt <= r_char_cnt + 16'd1;
    end

    assign char_cnt = r_char_cnt;
`endif

endmodule

// File: tb/tb_caesar_decrypt.sv
// Directed-vector bench for caesar_decrypt; expected plaintext is hand-computed per vector.
module tb_caesar_decrypt;

    logic       clock;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [4:0] shift;
    logic [1:0] direction;
    logic [7:0] dout;
    logic       v;
    logic       dout_ready;
`ifdef CAESAR_DEC_CNT_EN
    logic [15:0] char_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int model_cnt = 0;
    logic [7:0] exp_q[$];

    caesar_decrypt #(.N(8), .DEPTH(4)) dut (
        .clock      (clock),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .shift      (shift),
        .direction  (direction),
        .dout       (dout),
        .v          (v),
        .dout_ready (dout_ready)
`ifdef CAESAR_DEC_CNT_EN
        ,
        .char_cnt   (char_cnt)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a byte from posedge+2 and hold it until it is accepted on a rising edge.
    task automatic push(input logic [7:0] b, input logic [4:0] s, input logic [1:0] d,
                        input logic [7:0] plain);
        int t;
        t = 0;
        din = b; shift = s; direction = d; din_valid = 1'b1;
        @(negedge clock);
        while (!din_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!din_ready) check("push_timeout", 32'(din_ready), 32'd1);
        @(posedge clock);
        exp_q.push_back(plain);
        #2;
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #2;
    endtask

    always @(negedge clock) begin
        if (rst && v && dout_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 32'(exp_q.size()), 32'd1);
            else begin
                check("dout", 32'(dout), 32'(exp_q.pop_front()));
                model_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b1; din = '0; din_valid = 1'b0;
        shift = '0; direction = '0; dout_ready = 1'b1;
        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_v", 32'(v), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);
        @(posedge clock); #2;
        rst = 1'b1;

        // Latency: v rises only after the third edge following acceptance.
        push(8'h49, 5'd1, 2'b00, 8'h48);
        @(negedge clock); check("lat_k", 32'(v), 32'd0);
        @(negedge clock); check("lat_k1", 32'(v), 32'd0);
        @(negedge clock); check("lat_k2", 32'(v), 32'd0);
        @(negedge clock); check("lat_k3", 32'(v), 32'd1);
        @(posedge clock); #2;
        push(8'h42, 5'd1, 2'b00, 8'h41);
        push(8'h4D, 5'd1, 2'b00, 8'h4C);
        drain();

        // Key reduction, wrap, non-letters and bypass, streamed back to back.
        push(8'h51, 5'd26, 2'b00, 8'h51);
        push(8'h61, 5'd27, 2'b00, 8'h7A);
        push(8'h78, 5'd5,  2'b10, 8'h63);
        push(8'h0B, 5'd5,  2'b00, 8'h0B);
        push(8'h4B, 5'd10, 2'b01, 8'h4B);
        push(8'h4B, 5'd3,  2'b11, 8'h4B);
        push(8'h41, 5'd1,  2'b00, 8'h5A);
        push(8'h7A, 5'd1,  2'b10, 8'h61);
        push(8'h6D, 5'd13, 2'b00, 8'h7A);
        push(8'h5B, 5'd1,  2'b00, 8'h5B);
        push(8'h60, 5'd1,  2'b10, 8'h60);
        push(8'h40, 5'd1,  2'b00, 8'h40);
        push(8'h5A, 5'd31, 2'b10, 8'h45);
        drain();

        // Mid-stream key change.
        push(8'h46, 5'd5,  2'b00, 8'h41);
        push(8'h4B, 5'd10, 2'b00, 8'h41);
        drain();

        // Backpressure: six bytes fill FIFO plus pipeline, output holds.
        dout_ready = 1'b0;
        push(8'h42, 5'd1, 2'b00, 8'h41);
        push(8'h43, 5'd1, 2'b00, 8'h42);
        push(8'h44, 5'd1, 2'b00, 8'h43);
        push(8'h45, 5'd1, 2'b00, 8'h44);
        push(8'h46, 5'd1, 2'b00, 8'h45);
        push(8'h47, 5'd1, 2'b00, 8'h46);
        @(negedge clock);
        check("full_din_ready", 32'(din_ready), 32'd0);
        check("hold_v", 32'(v), 32'd1);
        check("hold_dout", 32'(dout), 32'h41);
        repeat (3) @(negedge clock);
        check("hold_dout_later", 32'(dout), 32'h41);
        check("full_din_ready_later", 32'(din_ready), 32'd0);
        @(posedge clock); #2;
        dout_ready = 1'b1;
        drain();

        // en=0 blocks acceptance but in-flight bytes still drain.
        push(8'h45, 5'd4, 2'b00, 8'h41);
        en = 1'b0;
        @(negedge clock);
        check("en0_din_ready", 32'(din_ready), 32'd0);
        drain();
        en = 1'b1;

        // Reset with three bytes in flight.
        push(8'h44, 5'd3, 2'b00, 8'h41);
        push(8'h45, 5'd3, 2'b00, 8'h42);
        push(8'h46, 5'd3, 2'b00, 8'h43);
        @(posedge clock); #2;
        check("v_before_rst", 32'(v), 32'd1);
        rst = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("rst_mid_v", 32'(v), 32'd0);
        check("rst_mid_din_ready", 32'(din_ready), 32'd0);
`ifdef CAESAR_DEC_CNT_EN
        check("rst_mid_char_cnt", 32'(char_cnt), 32'd0);
`endif
        @(posedge clock); #2;
        rst = 1'b1;
        repeat (4) @(negedge clock);
        check("post_rst_empty_v", 32'(v), 32'd0);
        @(posedge clock); #2;
        push(8'h62, 5'd1, 2'b00, 8'h61);
        drain();
`ifdef CAESAR_DEC_CNT_EN
        check("char_cnt", 32'(char_cnt), 32'(model_cnt));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
